// File: rtl/weight_fetch_sched.sv
// weight_fetch_sched: walks one layer's weight blocks phase by phase.
// For every phase it pulses the store's load low (re-init), raises load,
// waits out the settle window, waits for the store's valid, then offers the
// frozen weight block to the conv datapath over a valid/ready handshake.
module weight_fetch_sched #(
  parameter int SETTLE  = 2,   // load-high cycles during which st_valid is stale
  parameter int GAP     = 1,   // load-low cycles before each phase (>= 1)
  parameter int TIMEOUT = 16   // max FETCH cycles from load rise
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] layer,
  input  logic [2:0] last_phase,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       st_load,
  output logic [3:0] st_cs,
  output logic [2:0] st_phase,
  input  logic       st_valid,
  output logic       w_valid,
  input  logic       w_ready,
  output logic [2:0] w_phase
);

  // Layer codes understood by the weight store; anything above AFFINE is invalid.
  localparam logic [3:0] LAYER0       = 4'd0;
  localparam logic [3:0] LAYER1       = 4'd1;
  localparam logic [3:0] LAYER2       = 4'd2;
  localparam logic [3:0] LAYER3       = 4'd3;
  localparam logic [3:0] LAYER_AFFINE = 4'd4;

  // One shared cycle counter serves both the ARM gap and the FETCH timeout.
  localparam int CW = $clog2(((TIMEOUT > GAP) ? TIMEOUT : GAP) + 1);
  localparam logic [CW-1:0] SETTLE_C   = CW'(SETTLE);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FETCH,
    S_HOLD,
    S_NEXT
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [2:0]    last_q,  last_d;
  logic [3:0]    layer_q, layer_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          err_q,   err_d;
  logic          layer_ok;

  assign layer_ok = (layer == LAYER0) || (layer == LAYER1) || (layer == LAYER2) ||
                    (layer == LAYER3) || (layer == LAYER_AFFINE);

  // State, latched request and counters; reset drops everything to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 3'd0;
      last_q  <= 3'd0;
      layer_q <= 4'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      last_q  <= last_d;
      layer_q <= layer_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    last_d  = last_q;
    layer_d = layer_q;
    cnt_d   = cnt_q + CNT_ONE;
    err_d   = 1'b0;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    st_load = 1'b0;
    w_valid = 1'b0;
    w_phase = 3'd0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (layer_ok) begin
            layer_d = layer;
            last_d  = last_phase;
            phase_d = 3'd0;
            state_d = S_ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // Load held low so the store re-inits before the next phase.
      S_ARM: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end

      // Valid is only trusted after the settle window; it wins over timeout.
      S_FETCH: begin
        st_load = 1'b1;
        if ((cnt_q >= SETTLE_C) && st_valid) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      // Load stays high so the store output remains frozen until accepted.
      S_HOLD: begin
        cnt_d   = '0;
        st_load = 1'b1;
        w_valid = 1'b1;
        w_phase = phase_q;
        if (w_ready) begin
          state_d = S_NEXT;
        end
      end

      // Either finish the layer or step to the next phase (no wrap past 7).
      S_NEXT: begin
        cnt_d = '0;
        if (phase_q == last_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q + 3'd1;
          state_d = S_ARM;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign err      = err_q;
  assign st_cs    = layer_q;
  assign st_phase = phase_q;

endmodule

// File: tb/tb_weight_fetch_sched.sv
// Bench for weight_fetch_sched: a table of whole-layer runs with hand-derived
// totals, hand sequences for stale valid, backpressure and mid-HOLD reset, and
// randomized runs. Every cycle is checked against a timestamp schedule built
// from the phase rules (ARM/FETCH/HOLD/NEXT lengths) with plain arithmetic.
`timescale 1ns/1ps
module tb_weight_fetch_sched;

  localparam int SETTLE  = 2;
  localparam int GAP     = 1;
  localparam int TIMEOUT = 16;

  localparam logic [3:0] L0   = 4'd0;
  localparam logic [3:0] L1   = 4'd1;
  localparam logic [3:0] L2   = 4'd2;
  localparam logic [3:0] L3   = 4'd3;
  localparam logic [3:0] LAFF = 4'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] layer;
  logic [2:0] last_phase;
  logic       busy, done, err, st_load;
  logic [3:0] st_cs;
  logic [2:0] st_phase;
  logic       st_valid;
  logic       w_valid, w_ready;
  logic [2:0] w_phase;

  always #5 clk = ~clk;

  weight_fetch_sched #(.SETTLE(SETTLE), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .layer(layer), .last_phase(last_phase),
    .busy(busy), .done(done), .err(err), .st_load(st_load), .st_cs(st_cs),
    .st_phase(st_phase), .st_valid(st_valid), .w_valid(w_valid),
    .w_ready(w_ready), .w_phase(w_phase)
  );

  int n_chk = 0;
  int n_err = 0;

  // Per-phase store delay (cycles after load rise) and consumer delay.
  int dly_a[8];
  int rdly_a[8];

  // Store / consumer model state.
  int   rise_cnt, nload, cur_ld, hold_cnt, nhold, cur_h;
  logic prev_load, prev_wv;

  typedef struct {
    logic [3:0] lay;
    logic [2:0] lp;
    int         dly;
    int         rdly;
    int         exp_blocks;
    int         exp_done;
    int         exp_err;
    int         exp_busy;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock, then let the store and consumer models respond.
  task automatic step();
    @(posedge clk);
    #1;
    if (st_load) begin
      if (!prev_load) begin
        rise_cnt = 0;
        cur_ld   = nload & 7;
        nload++;
      end else begin
        rise_cnt++;
      end
      // Before SETTLE the store still shows whatever valid it had (stale).
      if (rise_cnt >= SETTLE) st_valid = (rise_cnt >= dly_a[cur_ld]);
    end
    prev_load = st_load;
    if (w_valid) begin
      if (!prev_wv) begin
        hold_cnt = 0;
        cur_h    = nhold & 7;
        nhold++;
      end else begin
        hold_cnt++;
      end
      w_ready = (hold_cnt >= rdly_a[cur_h]);
    end else begin
      w_ready = 1'($urandom_range(0, 1));
    end
    prev_wv = w_valid;
  endtask

  task automatic set_delays(input int d, input int r);
    for (int p = 0; p < 8; p++) begin
      dly_a[p]  = d;
      rdly_a[p] = r;
    end
  endtask

  // One layer request, checked cycle by cycle against the phase schedule.
  task automatic run(input logic [3:0] lay, input logic [2:0] lp, input bit start_at_done,
                     output int nb, output int nd, output int ne, output int nbusy);
    int L[8], H[8], N[8], A[8];
    int np, err_c, done_c, end_c, bs_c, t, eff, exp_ph, exp_wph, exp_blocks;
    bit ok, exp_load, exp_wv, exp_busy;
    nb = 0; nd = 0; ne = 0; nbusy = 0;
    nload = 0; nhold = 0;
    ok = (lay <= LAFF);
    np = 0; err_c = -1; done_c = -1; end_c = 1; exp_blocks = 0;
    if (!ok) begin
      err_c = 1;
      end_c = 1;
    end else begin
      t = 1 + GAP;
      for (int p = 0; p <= int'(lp); p++) begin
        A[p] = t - GAP;
        L[p] = t;
        np   = p + 1;
        eff  = (dly_a[p] > SETTLE) ? dly_a[p] : SETTLE;
        if (eff > TIMEOUT - 1) begin
          err_c = t + TIMEOUT;
          H[p]  = err_c;
          N[p]  = err_c;
          end_c = err_c;
          break;
        end
        H[p] = t + eff + 1;
        N[p] = H[p] + rdly_a[p] + 1;
        exp_blocks++;
        if (p == int'(lp)) begin
          done_c = N[p];
          end_c  = N[p] + 1;
        end else begin
          t = N[p] + 1 + GAP;
        end
      end
    end
    bs_c = (ok && end_c > 2) ? $urandom_range(1, end_c - 1) : -1;

    layer = lay; last_phase = lp; start = 1'b1;
    for (int c = 1; c <= end_c + 2; c++) begin
      step();
      start = 1'b0;
      layer = 4'($urandom);
      last_phase = 3'($urandom);
      exp_load = 0; exp_wv = 0; exp_wph = 0; exp_ph = 0;
      for (int p = 0; p < np; p++) begin
        if (c >= L[p] && c < N[p]) exp_load = 1;
        if (c >= H[p] && c < N[p]) begin exp_wv = 1; exp_wph = p; end
        if (c >= A[p]) exp_ph = p;
      end
      exp_busy = ok && (c < end_c);
      chk($sformatf("busy L%0d c%0d", lay, c), int'(busy), int'(exp_busy));
      chk($sformatf("done L%0d c%0d", lay, c), int'(done), int'(c == done_c));
      chk($sformatf("err L%0d c%0d", lay, c), int'(err), int'(c == err_c));
      chk($sformatf("st_load L%0d c%0d", lay, c), int'(st_load), int'(exp_load));
      chk($sformatf("w_valid L%0d c%0d", lay, c), int'(w_valid), int'(exp_wv));
      if (exp_busy) begin
        chk($sformatf("st_cs c%0d", c), int'(st_cs), int'(lay));
        chk($sformatf("st_phase c%0d", c), int'(st_phase), exp_ph);
      end
      if (exp_wv) chk($sformatf("w_phase c%0d", c), int'(w_phase), exp_wph);
      nbusy += int'(busy);
      nd    += int'(done);
      ne    += int'(err);
      nb    += int'(w_valid && w_ready);
      if (c == bs_c) begin
        start = 1'b1; layer = L3; last_phase = 3'd5;
      end
      if (start_at_done && c == done_c) begin
        start = 1'b1; layer = L2; last_phase = 3'd0;
      end
    end
    start = 1'b0;
    if (ok) chk($sformatf("blocks L%0d", lay), nb, exp_blocks);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int nb, nd, ne, nbusy;
    bit found;

    tbl[0] = '{L1,   3'd7, 5,  0, 8, 1, 0, 72};
    tbl[1] = '{LAFF, 3'd1, 5,  0, 2, 1, 0, 18};
    tbl[2] = '{4'hF, 3'd3, 5,  0, 0, 0, 1, 0};
    tbl[3] = '{L0,   3'd0, 99, 0, 0, 0, 1, 17};
    tbl[4] = '{L2,   3'd3, 0,  0, 4, 1, 0, 24};
    tbl[5] = '{L3,   3'd2, 15, 1, 3, 1, 0, 60};
    tbl[6] = '{L1,   3'd0, 16, 0, 0, 0, 1, 17};

    rst = 1'b0; start = 1'b0; layer = 4'd0; last_phase = 3'd0;
    st_valid = 1'b0; w_ready = 1'b0;
    prev_load = 1'b0; prev_wv = 1'b0; rise_cnt = 0; hold_cnt = 0;
    nload = 0; nhold = 0; cur_ld = 0; cur_h = 0;
    set_delays(5, 0);
    #1 rst = 1'b1;
    step();
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    chk("reset st_load", int'(st_load), 0);
    chk("reset st_cs", int'(st_cs), 0);
    chk("reset st_phase", int'(st_phase), 0);
    chk("reset w_valid", int'(w_valid), 0);
    chk("reset w_phase", int'(w_phase), 0);
    step();
    rst = 1'b0;
    step();

    // Table of whole-layer runs with hand-derived totals.
    for (int i = 0; i < 7; i++) begin
      set_delays(tbl[i].dly, tbl[i].rdly);
      run(tbl[i].lay, tbl[i].lp, 1'b0, nb, nd, ne, nbusy);
      chk($sformatf("tbl%0d blocks", i), nb, tbl[i].exp_blocks);
      chk($sformatf("tbl%0d done", i), nd, tbl[i].exp_done);
      chk($sformatf("tbl%0d err", i), ne, tbl[i].exp_err);
      chk($sformatf("tbl%0d busy cycles", i), nbusy, tbl[i].exp_busy);
      step();
    end

    // Stale valid already high at load rise must not cut the settle window.
    set_delays(5, 0);
    st_valid = 1'b1;
    run(L1, 3'd0, 1'b0, nb, nd, ne, nbusy);
    chk("stale busy cycles", nbusy, 9);

    // Backpressure on phase 2, plus a start coinciding with done.
    set_delays(5, 0);
    rdly_a[2] = 10;
    run(L1, 3'd3, 1'b1, nb, nd, ne, nbusy);
    chk("backpressure blocks", nb, 4);
    chk("backpressure busy cycles", nbusy, 46);
    step();

    // Reset in the middle of HOLD for phase 4.
    set_delays(5, 0);
    rdly_a[4] = 30;
    nload = 0; nhold = 0;
    layer = L2; last_phase = 3'd7; start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (w_valid && w_phase == 3'd4) found = 1'b1;
    end
    chk("reach HOLD phase 4", int'(found), 1);
    #3 rst = 1'b1;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst err", int'(err), 0);
    chk("midrst st_load", int'(st_load), 0);
    chk("midrst st_cs", int'(st_cs), 0);
    chk("midrst st_phase", int'(st_phase), 0);
    chk("midrst w_valid", int'(w_valid), 0);
    chk("midrst w_phase", int'(w_phase), 0);
    step();
    rst = 1'b0;
    step();
    set_delays(5, 0);
    run(L3, 3'd2, 1'b0, nb, nd, ne, nbusy);
    chk("restart done", nd, 1);
    step();

    // Randomized layers, phase counts and store/consumer delays.
    for (int i = 0; i < 25; i++) begin
      for (int p = 0; p < 8; p++) begin
        dly_a[p]  = $urandom_range(0, 17);
        rdly_a[p] = $urandom_range(0, 3);
      end
      run(4'($urandom_range(0, 6)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          nb, nd, ne, nbusy);
      chk($sformatf("rand%0d single outcome", i), nd + ne, 1);
      repeat ($urandom_range(1, 3)) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
